// File: rtl/mul24_seq_pkg.sv
// Shared types and constants for the time-shared 24x24 multiplier sequencer.
package mul24_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [1:0] phase_t;

    localparam logic [1:0] FULL_PREC_DEF = 2'b11;

    // Per-phase left shift of the partial product, in units of one operand half.
    localparam int unsigned SHIFT_LL = 0;
    localparam int unsigned SHIFT_LH = 1;
    localparam int unsigned SHIFT_HL = 1;
    localparam int unsigned SHIFT_HH = 2;

    function automatic int unsigned phase_shift(input phase_t phase, input int unsigned half_w);
        int unsigned units;
        case (phase)
            2'd0:    units = SHIFT_LL;
            2'd1:    units = SHIFT_LH;
            2'd2:    units = SHIFT_HL;
            2'd3:    units = SHIFT_HH;
            default: units = SHIFT_LL;
        endcase
        return units * half_w;
    endfunction

endpackage

// File: rtl/mul24_seq_ctrl_mul12x12_core.sv
// Combinational unsigned HALF_W x HALF_W product unit; the only multiplier in the sequencer.
module mul12x12_core #(
    parameter int HALF_W = 12
) (
    input  logic [HALF_W-1:0]   a,
    input  logic [HALF_W-1:0]   b,
    output logic [2*HALF_W-1:0] product
);

    assign product = (2*HALF_W)'(a) * (2*HALF_W)'(b);

endmodule

// File: rtl/mul24_seq_ctrl.sv
// Four-pass (LL, LH, HL, HH) 24x24 multiplier sequencer around one 12x12 product unit.
// Optional build macro: MUL24_FAST_ACCEPT_EN (accept a new operand set in the result-handshake cycle).
module mul24_seq_ctrl
    import mul24_seq_pkg::*;
#(
    parameter int         HALF_W    = 12,
    parameter int         DATA_W    = 24,
    parameter logic [1:0] FULL_PREC = FULL_PREC_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [1:0]          i_Numerical_Precision,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [2*DATA_W-1:0] o_result,
    output logic                o_busy
);

    state_t                state_r;
    phase_t                phase_r;
    logic [2*DATA_W-1:0]   acc_r;
    logic [DATA_W-1:0]     a_r;
    logic [DATA_W-1:0]     b_r;
    logic                  full_r;
    logic                  valid_r;
    logic                  busy_r;
    logic [2*DATA_W-1:0]   result_r;

    logic [HALF_W-1:0]     a_half_s;
    logic [HALF_W-1:0]     b_half_s;
    logic [2*HALF_W-1:0]   pp_s;
    logic [2*DATA_W-1:0]   pp_shifted_s;
    logic [2*DATA_W-1:0]   acc_next_s;
    logic                  last_phase_s;
    logic                  ready_s;
    logic                  accept_s;

    // Ready depends on i_ready in fast-accept builds so the handshake cycle can also accept.
    always_comb begin
`ifdef MUL24_FAST_ACCEPT_EN
        ready_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && i_ready);
`else
        ready_s = (state_r == ST_IDLE);
`endif
        accept_s = i_valid && ready_s;
    end

    // Operand-half selection for the current pass.
    always_comb begin
        case (phase_r)
            2'd0: begin a_half_s = a_r[HALF_W-1:0];      b_half_s = b_r[HALF_W-1:0];      end
            2'd1: begin a_half_s = a_r[HALF_W-1:0];      b_half_s = b_r[DATA_W-1:HALF_W]; end
            2'd2: begin a_half_s = a_r[DATA_W-1:HALF_W]; b_half_s = b_r[HALF_W-1:0];      end
            2'd3: begin a_half_s = a_r[DATA_W-1:HALF_W]; b_half_s = b_r[DATA_W-1:HALF_W]; end
            default: begin a_half_s = a_r[HALF_W-1:0];   b_half_s = b_r[HALF_W-1:0];      end
        endcase
    end

    mul12x12_core #(
        .HALF_W (HALF_W)
    ) u_core (
        .a       (a_half_s),
        .b       (b_half_s),
        .product (pp_s)
    );

    // Shifted accumulation of the current partial product.
    always_comb begin
        pp_shifted_s = {{(2*DATA_W-2*HALF_W){1'b0}}, pp_s} << phase_shift(phase_r, HALF_W);
        acc_next_s   = acc_r + pp_shifted_s;
        last_phase_s = (!full_r) || (phase_r == 2'd3);
    end

    // Operand capture on accept; held for the whole run.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_r    <= {DATA_W{1'b0}};
            b_r    <= {DATA_W{1'b0}};
            full_r <= 1'b0;
        end else if (accept_s) begin
            a_r    <= i_a;
            b_r    <= i_b;
            full_r <= (i_Numerical_Precision == FULL_PREC);
        end
    end

    // Sequencer FSM with registered valid, busy and result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r  <= ST_IDLE;
            phase_r  <= 2'd0;
            acc_r    <= {(2*DATA_W){1'b0}};
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            result_r <= {(2*DATA_W){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r <= ST_RUN;
                        phase_r <= 2'd0;
                        acc_r   <= {(2*DATA_W){1'b0}};
                        busy_r  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_next_s;
                    if (last_phase_s) begin
                        result_r <= acc_next_s;
                        valid_r  <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        phase_r <= phase_r + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        valid_r <= 1'b0;
                        // accept_s can only be true here in fast-accept builds.
                        if (accept_s) begin
                            state_r <= ST_RUN;
                            phase_r <= 2'd0;
                            acc_r   <= {(2*DATA_W){1'b0}};
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    phase_r <= 2'd0;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready  = ready_s;
    assign o_valid  = valid_r;
    assign o_busy   = busy_r;
    assign o_result = result_r;

endmodule

// File: tb/tb_mul24_seq_ctrl.sv
// Self-checking bench for mul24_seq_ctrl: directed corner cases plus randomized back-to-back traffic.
module tb_mul24_seq_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_Numerical_Precision;
    logic [23:0] i_a;
    logic [23:0] i_b;
    logic        o_valid;
    logic        i_ready;
    logic [47:0] o_result;
    logic        o_busy;

    int n_checks;
    int n_fail;

    mul24_seq_ctrl dut (
        .i_clk                 (i_clk),
        .i_rst                 (i_rst),
        .i_valid               (i_valid),
        .o_ready               (o_ready),
        .i_Numerical_Precision (i_Numerical_Precision),
        .i_a                   (i_a),
        .i_b                   (i_b),
        .o_valid               (o_valid),
        .i_ready               (i_ready),
        .o_result              (o_result),
        .o_busy                (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference product straight from the precision rule.
    function automatic logic [47:0] ref_mul(input logic [1:0] prec, input logic [23:0] a, input logic [23:0] b);
        logic [47:0] wa;
        logic [47:0] wb;
        if (prec == 2'b11) begin
            wa = {24'd0, a};
            wb = {24'd0, b};
        end else begin
            wa = {36'd0, a[11:0]};
            wb = {36'd0, b[11:0]};
        end
        return wa * wb;
    endfunction

    function automatic int exp_spacing(input logic full);
`ifdef MUL24_FAST_ACCEPT_EN
        return full ? 5 : 2;
`else
        return full ? 6 : 3;
`endif
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One transaction: accept, latency, result, optional stall in DONE, handshake.
    task automatic run_op(input logic [1:0] prec, input logic [23:0] a, input logic [23:0] b, input int hold);
        logic [47:0] exp;
        logic [47:0] held;
        int lat;
        exp = ref_mul(prec, a, b);
        chk_val("ready_before_accept", {63'd0, o_ready}, 64'd1);
        i_Numerical_Precision = prec;
        i_a = a;
        i_b = b;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_a = 24'($urandom);
        i_b = 24'($urandom);
        i_Numerical_Precision = 2'($urandom);
        lat = 0;
        while (!o_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk_val("latency", 64'(lat), (prec == 2'b11) ? 64'd4 : 64'd1);
        chk_val("result", {16'd0, o_result}, {16'd0, exp});
        chk_val("busy_in_done", {63'd0, o_busy}, 64'd1);
        held = o_result;
        if (hold > 0) begin
            i_valid = 1'b1;
            for (int k = 0; k < hold; k++) begin
                tick();
                chk_val("stall_valid", {63'd0, o_valid}, 64'd1);
                chk_val("stall_result", {16'd0, o_result}, {16'd0, held});
                chk_val("stall_ready", {63'd0, o_ready}, 64'd0);
            end
            i_valid = 1'b0;
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk_val("post_hs_valid", {63'd0, o_valid}, 64'd0);
        chk_val("post_hs_result", {16'd0, o_result}, {16'd0, held});
        chk_val("post_hs_busy", {63'd0, o_busy}, 64'd0);
    endtask

    // Continuous traffic with i_ready held high; checks results in order and accept spacing.
    task automatic run_stream(input int n_ops);
        logic [47:0] exp_q[$];
        logic        full_q[$];
        int sent;
        int done;
        int cyc;
        int last_acc;
        logic prev_full;
        logic acc_now;
        logic [47:0] e;
        sent = 0;
        done = 0;
        cyc = 0;
        last_acc = -1;
        prev_full = 1'b0;
        i_ready = 1'b1;
        i_Numerical_Precision = 2'($urandom_range(0, 3));
        i_a = 24'($urandom);
        i_b = 24'($urandom);
        i_valid = 1'b1;
        while (done < n_ops && cyc < 2000) begin
            acc_now = i_valid && o_ready;
            if (o_valid) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk_val("stream_result", {16'd0, o_result}, {16'd0, e});
                end else begin
                    chk_val("stream_unexpected_valid", 64'd1, 64'd0);
                end
                done++;
            end
            if (acc_now) begin
                exp_q.push_back(ref_mul(i_Numerical_Precision, i_a, i_b));
                full_q.push_back(i_Numerical_Precision == 2'b11);
                if (last_acc >= 0)
                    chk_val("stream_spacing", 64'(cyc - last_acc), 64'(exp_spacing(prev_full)));
                last_acc = cyc;
                prev_full = (i_Numerical_Precision == 2'b11);
            end
            tick();
            cyc++;
            if (acc_now) begin
                sent++;
                if (sent < n_ops) begin
                    i_Numerical_Precision = 2'($urandom_range(0, 3));
                    i_a = 24'($urandom);
                    i_b = 24'($urandom);
                end else begin
                    i_valid = 1'b0;
                end
            end
        end
        chk_val("stream_completed", 64'(done), 64'(n_ops));
        i_valid = 1'b0;
        i_ready = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        i_rst = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_Numerical_Precision = 2'b00;
        i_a = 24'd0;
        i_b = 24'd0;
        repeat (2) tick();
        chk_val("reset_valid", {63'd0, o_valid}, 64'd0);
        chk_val("reset_result", {16'd0, o_result}, 64'd0);
        chk_val("reset_busy", {63'd0, o_busy}, 64'd0);
        chk_val("reset_ready", {63'd0, o_ready}, 64'd1);
        i_rst = 1'b0;
        tick();

        run_op(2'b11, 24'hFFFFFF, 24'hFFFFFF, 0);
        run_op(2'b11, 24'h123456, 24'h000002, 0);
        run_op(2'b00, 24'hABC123, 24'h000FFF, 0);
        run_op(2'b11, 24'h00ABCD, 24'h765432, 3);
        run_op(2'b01, 24'hFFFFFF, 24'hFFFFFF, 0);

        // Reset during phase 2 of a full-mode run.
        i_Numerical_Precision = 2'b11;
        i_a = 24'h345678;
        i_b = 24'h9ABCDE;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        repeat (2) tick();
        i_rst = 1'b1;
        #1;
        chk_val("midrun_rst_valid", {63'd0, o_valid}, 64'd0);
        chk_val("midrun_rst_result", {16'd0, o_result}, 64'd0);
        chk_val("midrun_rst_busy", {63'd0, o_busy}, 64'd0);
        chk_val("midrun_rst_ready", {63'd0, o_ready}, 64'd1);
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_val("post_rst_no_valid", {63'd0, o_valid}, 64'd0);
        end
        run_op(2'b11, 24'h000010, 24'h000010, 0);
        chk_val("after_rst_product", {16'd0, o_result}, 64'h100);

        for (int k = 0; k < 8; k++)
            run_op(2'($urandom_range(0, 3)), 24'($urandom), 24'($urandom), int'($urandom_range(0, 2)));

        run_stream(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
